enigma_msg_feeder: RTL

ENIGMA_MSG_FEEDER -- requirements
Module: enigma_msg_feeder

---
 rtl/enigma_pkg.sv | 16 +
 rtl/enigma_sym_ram.sv | 24 ++
 rtl/enigma_msg_feeder.sv | 108 ++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma cipher datapath: symbol format and
// the message-feeder FSM state encoding.
package enigma_pkg;

  localparam int SW = 7;

  typedef logic signed [SW-1:0] symbol_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PREP,
    SEND
  } feeder_state_t;

endpackage

// File: rtl/enigma_sym_ram.sv
// Simple dual-port symbol buffer: one synchronous write port, one
// synchronous (one-cycle latency) read port.
module enigma_sym_ram #(
  parameter int DEPTH = 128,
  parameter int SW    = 7
) (
  input  logic                       clk_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic signed [SW-1:0]       wr_data_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
  output logic signed [SW-1:0]       rd_data_o
);

  logic signed [SW-1:0] mem [DEPTH];

  // Write port and registered read port share the clock.
  // NOTE: the array has no reset so it maps onto block RAM; every slot is written before it is read.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/enigma_msg_feeder.sv
// Collects one message of upstream symbols, then replays it to the cipher
// core as a contiguous burst preceded by a one-cycle rotor reset pulse.
module enigma_msg_feeder #(
  parameter int DEPTH = 128,
  parameter int SW    = enigma_pkg::SW
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_val_i,
  input  logic signed [SW-1:0] wr_symbol_i,
  input  logic                 wr_last_i,
  output logic                 wr_rdy_o,
  input  logic                 abort_i,
  output logic                 rotors_rst_o,
  output logic [7:0]           symb_numb_o,
  output logic                 symb_val_o,
  output logic signed [SW-1:0] symbol_o,
  output logic                 ovf_o
);

  import enigma_pkg::*;

  localparam int AW = $clog2(DEPTH);

  feeder_state_t        state, state_nxt;
  logic [AW:0]          wp, rp;
  logic [AW-1:0]        last_idx;
  logic [AW:0]          last_end;
  logic                 wr_acc, at_end, wr_close, send_done;
  logic signed [SW-1:0] rd_data;

  // Handshake and message-closure decode; abort wins over a write.
  assign wr_rdy_o  = rst_n_i && ((state == IDLE) || (state == LOAD));
  assign wr_acc    = wr_val_i && wr_rdy_o && !abort_i;
  assign at_end    = (wp == (AW+1)'(DEPTH-1));
  assign wr_close  = wr_acc && (wr_last_i || at_end);
  assign ovf_o     = wr_acc && at_end && !wr_last_i;
  assign last_end  = {1'b0, last_idx} + (AW+1)'(1);
  // rp runs one ahead of the symbol being presented, so the burst ends when it passes N-1.
  assign send_done = (rp == last_end);
  assign symbol_o  = symb_val_o ? rd_data : '0;

  enigma_sym_ram #(.DEPTH(DEPTH), .SW(SW)) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wp[AW-1:0]),
    .wr_data_i (wr_symbol_i),
    .rd_addr_i (rp[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (wr_close) state_nxt = PREP;
                 else if (wr_acc) state_nxt = LOAD;
        LOAD:    if (wr_close) state_nxt = PREP;
        PREP:    state_nxt = SEND;
        SEND:    if (send_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Write/read pointers and captured last index.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp       <= '0;
      rp       <= '0;
      last_idx <= '0;
    end else if (abort_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_acc) wp <= wr_close ? '0 : wp + (AW+1)'(1);
      if (wr_close) last_idx <= wp[AW-1:0];
      // PREP issues the read of slot 0; SEND prefetches the following slot each cycle.
      if (state == PREP)      rp <= (AW+1)'(1);
      else if (state == SEND) rp <= send_done ? '0 : rp + (AW+1)'(1);
    end
  end

  // Registered burst control outputs toward the cipher core.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rotors_rst_o <= 1'b0;
      symb_val_o   <= 1'b0;
      symb_numb_o  <= '0;
    end else begin
      rotors_rst_o <= (state_nxt == PREP);
      symb_val_o   <= (state_nxt == SEND);
      if (state == PREP) symb_numb_o <= 8'(last_idx);
    end
  end

endmodule
